macc_seq_ctrl: RTL and testbench

- Sequences one dot-product job of cfg_num_chunks × NUM_INPUTS int8 pairs through the shared macc array.
- Issues operand-buffer reads and drives macc i_valid, one chunk per cycle.
- Accumulates the signed partial sums returned on macc o_valid, then presents the final sum on a valid/ready result port.
- Sits between the layer scheduler (start/done) and the macc plus its two operand buffers.

---
 rtl/macc_pkg.sv | 17 +
 rtl/macc_seq_acc.sv | 49 ++++
 rtl/macc_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_macc_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macc_pkg.sv
// Shared definitions for the macc sequencer, the macc array and its adder tree.
package macc_pkg;

  // Sequencer states, exposed on the debug port of macc_seq_ctrl.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  // Width of a signed partial sum: int8*int8 products (16 bits) summed over n lanes.
  function automatic int psum_w(input int n);
    return 16 + $clog2(n);
  endfunction

endpackage

// File: rtl/macc_seq_acc.sv
// Sign-extending accumulator with clear/init/add and a count of accepted returns.
// The next-state values are exported so the controller can finish a job on the
// same edge the last partial sum is absorbed.
module macc_seq_acc #(
  parameter int PSUM_W = 21,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic        [ACC_W-1:0]  init_val,
  input  logic                     add_en,
  input  logic signed [PSUM_W-1:0] add_data,
  output logic        [ACC_W-1:0]  acc_nxt,
  output logic        [CNT_W-1:0]  ret_cnt_nxt
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  // Clear loads the initial value; otherwise each valid return adds in and is counted.
  always_comb begin
    acc_d     = acc_q;
    ret_cnt_d = ret_cnt_q;
    if (clr) begin
      acc_d     = init_val;
      ret_cnt_d = '0;
    end else if (add_en) begin
      acc_d     = acc_q + ACC_W'(add_data);
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
    end
  end

  // Accumulator and return-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      ret_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign acc_nxt     = acc_d;
  assign ret_cnt_nxt = ret_cnt_d;

endmodule

// File: rtl/macc_seq_ctrl.sv
// Sequences one dot-product job through the shared macc array: issues operand
// buffer reads (one chunk per cycle), accumulates returned partial sums and
// presents the final sum on a valid/ready result port.
// Handshake: the result transfers on a cycle where res_valid && res_ready are
// both high; res_valid and res_data stay stable until that cycle.
// Optional build macro MACC_SEQ_BIAS_EN adds cfg_bias, the accumulator start value.
module macc_seq_ctrl
  import macc_pkg::*;
#(
  parameter  int NUM_INPUTS = 20,
  parameter  int ADDR_W     = 10,
  parameter  int CNT_W      = 10,
  parameter  int ACC_W      = 32,
  localparam int PSUM_W     = psum_w(NUM_INPUTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic        [ADDR_W-1:0] cfg_base_addr,
  input  logic        [CNT_W-1:0]  cfg_num_chunks,
`ifdef MACC_SEQ_BIAS_EN
  input  logic signed [31:0]       cfg_bias,
`endif
  output logic                     busy,
  output logic                     buf_rd_en,
  output logic        [ADDR_W-1:0] buf_rd_addr,
  output logic                     macc_i_valid,
  input  logic signed [PSUM_W-1:0] macc_o_data,
  input  logic                     macc_o_valid,
  output logic        [ACC_W-1:0]  res_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output state_e                   dbg_state
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              i_valid_q, i_valid_d;
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_data_q, res_data_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  issue_idx_q, issue_idx_d;

  logic              acc_clr;
  logic              acc_add;
  logic [ACC_W-1:0]  init_val;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]  ret_cnt_nxt;
  logic              ret_done;

`ifdef MACC_SEQ_BIAS_EN
  assign init_val = ACC_W'(cfg_bias);
`else
  assign init_val = '0;
`endif

  // Partial sums only count while a job is issuing or draining.
  assign acc_add  = macc_o_valid && (state_q == ST_ISSUE || state_q == ST_DRAIN);
  // All returns, including one absorbed on this edge, have arrived.
  assign ret_done = (ret_cnt_nxt == count_q);

  macc_seq_acc #(
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (acc_clr),
    .init_val    (init_val),
    .add_en      (acc_add),
    .add_data    (macc_o_data),
    .acc_nxt     (acc_nxt),
    .ret_cnt_nxt (ret_cnt_nxt)
  );

  // Next-state and registered-output logic of the job sequencer.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    i_valid_d   = rd_en_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    base_d      = base_q;
    count_d     = count_q;
    issue_idx_d = issue_idx_q;
    acc_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = cfg_base_addr;
          count_d = cfg_num_chunks;
          busy_d  = 1'b1;
          acc_clr = 1'b1;
          if (cfg_num_chunks == '0) begin
            state_d     = ST_RESULT;
            res_valid_d = 1'b1;
            res_data_d  = init_val;
            issue_idx_d = '0;
          end else begin
            state_d     = ST_ISSUE;
            rd_en_d     = 1'b1;
            rd_addr_d   = cfg_base_addr;
            issue_idx_d = CNT_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        if (issue_idx_q == count_q) begin
          if (ret_done) begin
            state_d     = ST_RESULT;
            res_valid_d = 1'b1;
            res_data_d  = acc_nxt;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          rd_en_d     = 1'b1;
          rd_addr_d   = base_q + ADDR_W'(issue_idx_q);
          issue_idx_d = issue_idx_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ret_done) begin
          state_d     = ST_RESULT;
          res_valid_d = 1'b1;
          res_data_d  = acc_nxt;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      i_valid_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      base_q      <= '0;
      count_q     <= '0;
      issue_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      i_valid_q   <= i_valid_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issue_idx_q <= issue_idx_d;
    end
  end

  assign busy         = busy_q;
  assign buf_rd_en    = rd_en_q;
  assign buf_rd_addr  = rd_addr_q;
  assign macc_i_valid = i_valid_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_macc_seq_ctrl.sv
// Bench for macc_seq_ctrl: models the operand buffers and a variable-latency
// macc around the DUT, predicts each job's address stream and final sum from
// the buffer contents, and checks the DUT every cycle on the falling edge.
module tb_macc_seq_ctrl;
  localparam int NI     = 20;
  localparam int AW     = 10;
  localparam int CW     = 10;
  localparam int ACCW   = 32;
  localparam int PW     = 16 + $clog2(NI);
  localparam int MAXL   = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 start;
  logic [AW-1:0]        cfg_base_addr;
  logic [CW-1:0]        cfg_num_chunks;
  logic signed [31:0]   cfg_bias;
  logic                 busy, buf_rd_en, macc_i_valid, res_valid, res_ready;
  logic [AW-1:0]        buf_rd_addr;
  logic [PW-1:0]        macc_o_data;
  logic                 macc_o_valid;
  logic [ACCW-1:0]      res_data;
  macc_pkg::state_e     dbg_state;

  macc_seq_ctrl #(.NUM_INPUTS(NI), .ADDR_W(AW), .CNT_W(CW), .ACC_W(ACCW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_chunks (cfg_num_chunks),
`ifdef MACC_SEQ_BIAS_EN
    .cfg_bias       (cfg_bias),
`endif
    .busy           (busy),
    .buf_rd_en      (buf_rd_en),
    .buf_rd_addr    (buf_rd_addr),
    .macc_i_valid   (macc_i_valid),
    .macc_o_data    (macc_o_data),
    .macc_o_valid   (macc_o_valid),
    .res_data       (res_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .dbg_state      (dbg_state)
  );

  // operand buffer contents
  byte signed a_mem [1024][NI];
  byte signed b_mem [1024][NI];

  // scoreboard / model state
  logic [AW-1:0]   exp_q[$];      // expected read addresses, in order
  int              rd_q[$];       // reads whose data is on its way to the macc
  logic [ACCW-1:0] exp_res;
  bit              exp_busy;
  bit              pv [MAXL];
  logic [PW-1:0]   pd [MAXL];
  int              lat;
  bit              prev_rd_en, prev_res_valid, prev_rdy;
  logic [ACCW-1:0] prev_res_data;
  logic [ACCW-1:0] last_res;
  bit              job_done;
  int              n_vec, n_err;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endfunction

  function automatic int psum(int addr);
    int s = 0;
    for (int l = 0; l < NI; l++) s += int'(a_mem[addr][l]) * int'(b_mem[addr][l]);
    return s;
  endfunction

  function automatic int inflight();
    int n = rd_q.size();
    for (int k = 0; k < MAXL; k++) if (pv[k]) n++;
    return n;
  endfunction

  task automatic fill_const(int base, int cnt, int va, int vb);
    for (int i = 0; i < cnt; i++)
      for (int l = 0; l < NI; l++) begin
        a_mem[(base + i) & 1023][l] = byte'(va);
        b_mem[(base + i) & 1023][l] = byte'(vb);
      end
  endtask

  task automatic fill_rand(int base, int cnt);
    for (int i = 0; i < cnt; i++)
      for (int l = 0; l < NI; l++) begin
        a_mem[(base + i) & 1023][l] = byte'($urandom_range(0, 255));
        b_mem[(base + i) & 1023][l] = byte'($urandom_range(0, 255));
      end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rd_q.delete();
    for (int k = 0; k < MAXL; k++) begin pv[k] = 1'b0; pd[k] = '0; end
    exp_busy = 1'b0; prev_rd_en = 1'b0; prev_res_valid = 1'b0; prev_rdy = 1'b0;
    prev_res_data = '0; job_done = 1'b0;
  endtask

  // One cycle, entered on a falling edge: check outputs, drive inputs, advance model.
  task automatic step(input bit st, input bit rdy);
    bit nb;
    int pa;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("macc_i_valid", 32'(macc_i_valid), 32'(prev_rd_en));
    if (buf_rd_en) begin
      if (exp_q.size() == 0) chk("unexpected_read", 32'(buf_rd_addr), 32'hFFFF_FFFF);
      else chk("rd_addr", 32'(buf_rd_addr), 32'(exp_q.pop_front()));
    end
    if (res_valid) begin
      chk("res_before_all_returns", 32'(exp_q.size() + inflight()), 32'd0);
      if (prev_res_valid && !prev_rdy) chk("res_data_hold", res_data, prev_res_data);
      if (rdy) begin
        chk("res_data", res_data, exp_res);
        last_res = res_data;
        job_done = 1'b1;
      end
    end else if (prev_res_valid && !prev_rdy) begin
      chk("res_valid_hold", 32'(res_valid), 32'd1);
    end

    // macc environment: buffer data reaches the macc with i_valid
    macc_o_valid = pv[0];
    macc_o_data  = pd[0];
    for (int k = 0; k < MAXL - 1; k++) begin pv[k] = pv[k+1]; pd[k] = pd[k+1]; end
    pv[MAXL-1] = 1'b0;
    if (macc_i_valid && rd_q.size() != 0) begin
      pa = rd_q.pop_front();
      pv[lat-1] = 1'b1;
      pd[lat-1] = PW'(psum(pa));
    end
    if (buf_rd_en) rd_q.push_back(int'(buf_rd_addr));
    // stray partial sums while idle or presenting a result must be ignored
    if (!macc_o_valid && inflight() == 0 && exp_q.size() == 0 &&
        (!exp_busy || res_valid) && $urandom_range(0, 3) == 0) begin
      macc_o_valid = 1'b1;
      macc_o_data  = PW'($urandom);
    end

    start     = st;
    res_ready = rdy;
    nb = exp_busy;
    if (st && !exp_busy) begin
`ifdef MACC_SEQ_BIAS_EN
      exp_res = ACCW'(cfg_bias);
`else
      exp_res = '0;
`endif
      for (int i = 0; i < int'(cfg_num_chunks); i++) begin
        exp_q.push_back(AW'((int'(cfg_base_addr) + i) & 1023));
        exp_res = exp_res + ACCW'(psum((int'(cfg_base_addr) + i) & 1023));
      end
      nb = 1'b1;
    end
    if (res_valid && rdy) nb = 1'b0;
    exp_busy       = nb;
    prev_rd_en     = buf_rd_en;
    prev_res_valid = res_valid;
    prev_rdy       = rdy;
    prev_res_data  = res_data;
    @(negedge clk);
  endtask

  int t_valid;

  // Run one job; res_ready is held low for `hold` cycles after start, then random.
  task automatic run_job(int base, int cnt, int bias, int hold, bit poke_start);
    int t;
    bit rdy, st;
    cfg_base_addr  = AW'(base);
    cfg_num_chunks = CW'(cnt);
    cfg_bias       = bias;
    job_done       = 1'b0;
    step(1'b1, 1'b0);
    // cfg must have been latched on the start edge
    cfg_base_addr  = AW'($urandom_range(0, 1023));
    cfg_num_chunks = CW'($urandom_range(0, 1023));
    cfg_bias       = int'($urandom);
    t = 0; t_valid = -1;
    while (!job_done && t < 300) begin
      if (res_valid && t_valid < 0) t_valid = t;
      rdy = (t >= hold) ? ($urandom_range(0, 2) != 0) : 1'b0;
      st  = poke_start && (t == hold / 2);
      step(st, rdy);
      t++;
    end
    if (!job_done) chk("job_timeout", 32'(t), 32'd0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd_en"}, 32'(buf_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(buf_rd_addr), 32'd0);
    chk({tag, "_i_valid"}, 32'(macc_i_valid), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
  endtask

  initial begin
    int b, c;
    n_vec = 0; n_err = 0; lat = 1;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    cfg_base_addr = '0; cfg_num_chunks = '0; cfg_bias = 0;
    macc_o_valid = 1'b0; macc_o_data = '0;
    last_res = '0;
    model_clear();
    fill_rand(0, 1024);
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single chunk, all-ones lanes
    fill_const(5, 1, 1, 1);
    lat = 1;
    run_job(5, 1, 0, 0, 1'b0);
    chk("lit_single", last_res, 32'd20);

    // four chunks of -128*-128
    fill_const(0, 4, -128, -128);
    lat = 3;
    run_job(0, 4, 0, 0, 1'b0);
    chk("lit_four_min", last_res, 32'd1310720);

    // empty job
    run_job(77, 0, -7, 0, 1'b0);
`ifdef MACC_SEQ_BIAS_EN
    chk("lit_empty", last_res, 32'hFFFF_FFF9);
`else
    chk("lit_empty", last_res, 32'd0);
`endif
    chk("empty_latency_ok", 32'(t_valid >= 0 && t_valid <= 1), 32'd1);

    // long back-pressure with an ignored start pulse
    fill_rand(100, 3);
    lat = 2;
    run_job(100, 3, 0, 10, 1'b1);

    // address wrap
    fill_const(1022, 4, 1, 1);
    lat = 1;
    run_job(1022, 4, 0, 0, 1'b0);
    chk("lit_wrap", last_res, 32'd80);

    // reset in the middle of issuing an 8-chunk job
    fill_rand(200, 8);
    lat = 2;
    cfg_base_addr = AW'(200); cfg_num_chunks = CW'(8); cfg_bias = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midjob_reset");
    model_clear();
    @(negedge clk);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    fill_const(0, 2, 2, 2);
    lat = 1;
    run_job(0, 2, 0, 0, 1'b0);
    chk("lit_after_reset", last_res, 32'd160);

    // random jobs
    for (int j = 0; j < 30; j++) begin
      b = int'($urandom_range(0, 1023));
      c = int'($urandom_range(0, 20));
      fill_rand(b, c);
      lat = int'($urandom_range(1, 4));
      run_job(b, c, int'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
